// File: rtl/fetch_align.sv
// fetch_align: instruction fetch front-end with a halfword realignment queue.
//   Fetches 32-bit words from instruction memory (one request outstanding at a
//   time), splits them into halfwords in a 4-entry FIFO and presents either a
//   compressed (16-bit) or a full 32-bit instruction to decode.
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   fch_redirect_i/_pc_i        : single-cycle PC redirect and its target
//   fch_mem_req_o/_addr_o/_ack_i: memory request, word address, acceptance
//   fch_mem_rvalid_i/_rdata_i   : memory read response
//   fch_inst_o/_pc_o/_com_inst_o: aligned instruction, its PC, compressed flag
//   fch_valid_o/fch_ready_i     : instruction handshake. An instruction moves
//                                 to decode in a cycle where valid & ready are
//                                 both high; valid never depends on ready.
module fetch_align #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fch_redirect_i,
   input  logic [31:0] fch_redirect_pc_i,
   output logic        fch_mem_req_o,
   output logic [31:0] fch_mem_addr_o,
   input  logic        fch_mem_ack_i,
   input  logic        fch_mem_rvalid_i,
   input  logic [31:0] fch_mem_rdata_i,
   output logic [31:0] fch_inst_o,
   output logic [31:0] fch_pc_o,
   output logic        fch_com_inst_o,
   output logic        fch_valid_o,
   input  logic        fch_ready_i
);

   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] pc_q, pc_d;
   logic [15:0] hq_q [4];
   logic [15:0] hq_d [4];
   logic [2:0]  count_q, count_d;
   logic        outstanding_q, outstanding_d;
   logic        stale_q, stale_d;
   logic        drop_low_q, drop_low_d;

   logic        head_is32;
   logic        accept;
   logic        consume;
   logic        rsp_take;
   logic [2:0]  n_pop;
   logic [2:0]  n_push;
   logic [15:0] push_hw [2];
   logic [3:0]  src;
   logic [3:0]  k;

   always_comb begin
      head_is32      = (hq_q[0][1:0] == 2'b11);
      // Requesting only with count <= 2 guarantees room for a full word.
      fch_mem_req_o  = !rst_i && !outstanding_q && (count_q <= 3'd2) && !fch_redirect_i;
      fch_mem_addr_o = fetch_addr_q;
      accept         = fch_mem_req_o && fch_mem_ack_i;

      fch_valid_o    = !rst_i && (((count_q >= 3'd1) && !head_is32) || (count_q >= 3'd2));
      fch_com_inst_o = fch_valid_o && !head_is32;
      fch_inst_o     = 32'h0;
      if (fch_valid_o) begin
         fch_inst_o = head_is32 ? {hq_q[1], hq_q[0]} : {16'h0, hq_q[0]};
      end
      fch_pc_o = pc_q;

      consume  = fch_valid_o && fch_ready_i;
      n_pop    = consume ? (head_is32 ? 3'd2 : 3'd1) : 3'd0;
      // Responses are only meaningful for our own live request.
      rsp_take = fch_mem_rvalid_i && outstanding_q && !stale_q;
      n_push   = rsp_take ? (drop_low_q ? 3'd1 : 3'd2) : 3'd0;
      push_hw[0] = drop_low_q ? fch_mem_rdata_i[31:16] : fch_mem_rdata_i[15:0];
      push_hw[1] = fch_mem_rdata_i[31:16];

      // Each new slot takes the surviving old entry after the pop, else the
      // next pushed halfword; unused slots simply hold.
      src = 4'd0;
      k   = 4'd0;
      for (int i = 0; i < 4; i++) begin
         hq_d[i] = hq_q[i];
         src = 4'(i) + {1'b0, n_pop};
         if (src < {1'b0, count_q}) begin
            hq_d[i] = hq_q[src[1:0]];
         end else begin
            k = src - {1'b0, count_q};
            if (k < {1'b0, n_push}) begin
               hq_d[i] = push_hw[k[0]];
            end
         end
      end

      count_d       = count_q + n_push - n_pop;
      pc_d          = consume ? (pc_q + (head_is32 ? 32'd4 : 32'd2)) : pc_q;
      fetch_addr_d  = accept ? (fetch_addr_q + 32'd4) : fetch_addr_q;
      outstanding_d = accept ? 1'b1 : (fch_mem_rvalid_i ? 1'b0 : outstanding_q);
      stale_d       = stale_q && !(fch_mem_rvalid_i && outstanding_q);
      drop_low_d    = drop_low_q && !rsp_take;

      // Redirect wins over consume and push. A response arriving in this same
      // cycle closes the old request, so it must not leave stale set behind.
      if (fch_redirect_i) begin
         count_d       = 3'd0;
         pc_d          = {fch_redirect_pc_i[31:1], 1'b0};
         fetch_addr_d  = {fch_redirect_pc_i[31:2], 2'b00};
         drop_low_d    = fch_redirect_pc_i[1];
         stale_d       = (outstanding_q && !fch_mem_rvalid_i) || accept;
         outstanding_d = (outstanding_q && !fch_mem_rvalid_i) || accept;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_addr_q  <= {RESET_PC[31:2], 2'b00};
         pc_q          <= RESET_PC;
         count_q       <= 3'd0;
         outstanding_q <= 1'b0;
         stale_q       <= 1'b0;
         drop_low_q    <= RESET_PC[1];
         for (int i = 0; i < 4; i++) hq_q[i] <= 16'h0;
      end else begin
         fetch_addr_q  <= fetch_addr_d;
         pc_q          <= pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         stale_q       <= stale_d;
         drop_low_q    <= drop_low_d;
         for (int i = 0; i < 4; i++) hq_q[i] <= hq_d[i];
      end
   end

endmodule
